// File: rtl/imem_loader.sv
// Boot-time instruction loader: accepts a length/data/checksum byte frame,
// writes big-endian 32-bit words into instruction memory and gates the core reset.
module imem_loader #(
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  byte_valid,
   input  logic [7:0]            byte_data,
   output logic                  byte_ready,
   output logic                  imem_we,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   output logic [31:0]           imem_wdata,
   output logic                  core_reset,
   output logic                  done,
   output logic                  error
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN_HI,
      S_LEN_LO,
      S_DATA,
      S_WRITE,
      S_CHK,
      S_DONE,
      S_ERROR
   } state_t;

   state_t                state;
   logic [7:0]            len_hi;
   logic [15:0]           word_cnt;
   logic [7:0]            chk_acc;
   logic [ADDR_WIDTH-1:0] word_idx;
   logic [1:0]            byte_cnt;
   logic [31:0]           word;

   logic                  accept;
   logic [15:0]           len_next;
   logic                  len_bad;
   logic                  last_word;
   logic [31:0]           word_next;

   always_comb begin
      byte_ready = (state == S_LEN_HI) || (state == S_LEN_LO) ||
                   (state == S_DATA)   || (state == S_CHK);
      accept     = byte_valid & byte_ready;
      len_next   = {len_hi, byte_data};
      // 17-bit compare so that a full 2^ADDR_WIDTH-word image is representable
      len_bad    = (len_next == 16'd0) || ({1'b0, len_next} > (17'd1 << ADDR_WIDTH));
      last_word  = (17'(word_idx) == ({1'b0, word_cnt} - 17'd1));
      word_next  = {word[23:0], byte_data};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= S_IDLE;
         len_hi     <= '0;
         word_cnt   <= '0;
         chk_acc    <= '0;
         word_idx   <= '0;
         byte_cnt   <= '0;
         word       <= '0;
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= '0;
         core_reset <= 1'b1;
         done       <= 1'b0;
         error      <= 1'b0;
      end else begin
         imem_we <= 1'b0;
         case (state)
            S_IDLE, S_DONE, S_ERROR: begin
               if (start) begin
                  state      <= S_LEN_HI;
                  chk_acc    <= '0;
                  word_idx   <= '0;
                  byte_cnt   <= '0;
                  word       <= '0;
                  core_reset <= 1'b1;
                  done       <= 1'b0;
                  error      <= 1'b0;
               end
            end
            S_LEN_HI: begin
               if (accept) begin
                  len_hi  <= byte_data;
                  chk_acc <= chk_acc ^ byte_data;
                  state   <= S_LEN_LO;
               end
            end
            S_LEN_LO: begin
               if (accept) begin
                  chk_acc  <= chk_acc ^ byte_data;
                  word_cnt <= len_next;
                  if (len_bad) begin
                     state <= S_ERROR;
                     error <= 1'b1;
                  end else begin
                     state    <= S_DATA;
                     word_idx <= '0;
                     byte_cnt <= '0;
                  end
               end
            end
            S_DATA: begin
               if (accept) begin
                  chk_acc  <= chk_acc ^ byte_data;
                  word     <= word_next;
                  byte_cnt <= byte_cnt + 2'd1;
                  // Write strobe and payload are registered on the 4th byte
                  if (byte_cnt == 2'd3) begin
                     state      <= S_WRITE;
                     imem_we    <= 1'b1;
                     imem_addr  <= word_idx;
                     imem_wdata <= word_next;
                  end
               end
            end
            S_WRITE: begin
               if (last_word) begin
                  state <= S_CHK;
               end else begin
                  word_idx <= word_idx + 1'b1;
                  state    <= S_DATA;
               end
            end
            S_CHK: begin
               if (accept) begin
                  if (byte_data == chk_acc) begin
                     state      <= S_DONE;
                     done       <= 1'b1;
                     core_reset <= 1'b0;
                  end else begin
                     state <= S_ERROR;
                     error <= 1'b1;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed and randomized frames against a frame-level model.
module tb_imem_loader;
   localparam int AW = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic          byte_valid;
   logic [7:0]    byte_data;
   logic          byte_ready;
   logic          imem_we;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_wdata;
   logic          core_reset;
   logic          done;
   logic          error;

   imem_loader #(.ADDR_WIDTH(AW)) dut (
      .clk(clk), .reset(reset), .start(start), .byte_valid(byte_valid),
      .byte_data(byte_data), .byte_ready(byte_ready), .imem_we(imem_we),
      .imem_addr(imem_addr), .imem_wdata(imem_wdata), .core_reset(core_reset),
      .done(done), .error(error)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int t_start = 0;
   logic [7:0]    frame[$];
   logic [AW-1:0] wr_addr[$];
   logic [31:0]   wr_data[$];

   always @(posedge clk) cyc <= cyc + 1;

   // Instruction-memory side: capture every write the core would see
   always @(posedge clk) begin
      if (imem_we) begin
         wr_addr.push_back(imem_addr);
         wr_data.push_back(imem_wdata);
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) if (imem_we) chk("ready_low_in_write", {31'd0, byte_ready}, 32'd0);

   task automatic check_reset_values(input string tag);
      chk({tag, "_ready"}, {31'd0, byte_ready}, 32'd0);
      chk({tag, "_we"}, {31'd0, imem_we}, 32'd0);
      chk({tag, "_addr"}, 32'(imem_addr), 32'd0);
      chk({tag, "_wdata"}, imem_wdata, 32'd0);
      chk({tag, "_core_reset"}, {31'd0, core_reset}, 32'd1);
      chk({tag, "_done"}, {31'd0, done}, 32'd0);
      chk({tag, "_error"}, {31'd0, error}, 32'd0);
   endtask

   task automatic build_frame(input int n, input bit good_chk);
      logic [7:0] x;
      logic [7:0] b;
      frame.delete();
      frame.push_back(8'(n >> 8));
      frame.push_back(8'(n));
      if (n >= 1 && n <= (1 << AW)) begin
         for (int i = 0; i < 4 * n; i++) begin
            b = 8'($urandom_range(0, 255));
            frame.push_back(b);
         end
         x = 8'd0;
         foreach (frame[i]) x ^= frame[i];
         if (!good_chk) x ^= 8'($urandom_range(1, 255));
         frame.push_back(x);
      end
   endtask

   // Start pulse, with a byte already presented to show it is not taken in IDLE/DONE/ERROR
   task automatic do_start();
      @(negedge clk);
      wr_addr.delete();
      wr_data.delete();
      start      = 1'b1;
      byte_valid = 1'b1;
      byte_data  = frame[0];
      chk("ready_low_before_start", {31'd0, byte_ready}, 32'd0);
      t_start = cyc + 1;
      @(negedge clk);
      start      = 1'b0;
      byte_valid = 1'b0;
      chk("core_reset_after_start", {31'd0, core_reset}, 32'd1);
      chk("done_after_start", {31'd0, done}, 32'd0);
      chk("error_after_start", {31'd0, error}, 32'd0);
      chk("ready_in_len_hi", {31'd0, byte_ready}, 32'd1);
   endtask

   // Drives frame bytes from the current negedge; returns how many were accepted
   task automatic send_bytes(input int count, input int gap_pct, output int sent);
      int  budget;
      bit  acc;
      sent   = 0;
      budget = 0;
      while (sent < count && budget < 20000) begin
         byte_valid = ($urandom_range(0, 99) >= gap_pct);
         byte_data  = frame[sent];
         acc = byte_valid && byte_ready;
         @(negedge clk);
         if (acc) sent++;
         budget++;
      end
      byte_valid = 1'b0;
   endtask

   task automatic send_frame(input int gap_pct, input bit timed);
      int         n;
      bit         len_ok;
      int         consume;
      int         sent;
      logic [7:0] x;
      bit         exp_done;
      logic [31:0] exp_w[$];
      n       = {frame[0], frame[1]};
      len_ok  = (n >= 1) && (n <= (1 << AW));
      consume = len_ok ? (2 + 4 * n + 1) : 2;
      exp_w.delete();
      exp_done = 1'b0;
      if (len_ok) begin
         for (int i = 0; i < n; i++)
            exp_w.push_back({frame[2+4*i], frame[3+4*i], frame[4+4*i], frame[5+4*i]});
         x = 8'd0;
         for (int i = 0; i < consume - 1; i++) x ^= frame[i];
         exp_done = (x == frame[consume-1]);
      end
      send_bytes(consume, gap_pct, sent);
      chk("bytes_consumed", sent, consume);
      chk("done_at_last_byte", {31'd0, done}, {31'd0, exp_done});
      if (timed && exp_done) chk("done_latency", cyc - t_start, 5 * n + 3);
      repeat (2) @(negedge clk);
      chk("ready_after_frame", {31'd0, byte_ready}, 32'd0);
      chk("done", {31'd0, done}, {31'd0, exp_done});
      chk("error", {31'd0, error}, {31'd0, !exp_done});
      chk("core_reset", {31'd0, core_reset}, {31'd0, !exp_done});
      chk("write_count", wr_data.size(), exp_w.size());
      for (int i = 0; i < exp_w.size() && i < wr_data.size(); i++) begin
         chk("write_addr", 32'(wr_addr[i]), i);
         chk("write_data", wr_data[i], exp_w[i]);
      end
   endtask

   initial begin
      int sent;
      reset      = 1'b1;
      start      = 1'b0;
      byte_valid = 1'b0;
      byte_data  = 8'd0;
      repeat (2) @(negedge clk);
      check_reset_values("reset");
      reset = 1'b0;
      @(negedge clk);
      check_reset_values("idle");

      // Happy path, back-to-back
      frame = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h0A, 8'h0C};
      do_start();
      send_frame(0, 1'b1);
      chk("happy_w0", (wr_data.size() > 0) ? wr_data[0] : 32'hx, 32'h20080005);
      chk("happy_w1", (wr_data.size() > 1) ? wr_data[1] : 32'hx, 32'h2009000A);

      // Bad checksum: words still written, error raised
      frame[10] = 8'h0D;
      do_start();
      send_frame(0, 1'b0);
      chk("badchk_error", {31'd0, error}, 32'd1);

      // Length bounds
      frame = '{8'h00, 8'h00};
      do_start();
      send_frame(0, 1'b0);
      chk("len0_error", {31'd0, error}, 32'd1);
      frame = '{8'h01, 8'h01};
      do_start();
      send_frame(0, 1'b0);
      chk("len257_error", {31'd0, error}, 32'd1);
      build_frame(256, 1'b1);
      do_start();
      send_frame(0, 1'b1);
      chk("len256_last_addr", (wr_addr.size() == 256) ? 32'(wr_addr[255]) : 32'hx, 32'hFF);

      // Backpressure on the happy-path frame
      frame = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h0A, 8'h0C};
      do_start();
      send_frame(40, 1'b0);

      // Randomized frames, lengths, gaps and checksums
      for (int k = 0; k < 8; k++) begin
         build_frame($urandom_range(1, 12), ($urandom_range(0, 3) != 0));
         do_start();
         send_frame($urandom_range(0, 50), 1'b0);
      end

      // Reset asserted during the 2nd word's WRITE of a 4-word frame
      build_frame(4, 1'b1);
      do_start();
      send_bytes(10, 0, sent);
      chk("midload_sent", sent, 10);
      chk("midload_we_high", {31'd0, imem_we}, 32'd1);
      #1 reset = 1'b1;
      #1 check_reset_values("midload");
      @(negedge clk);
      reset = 1'b0;
      chk("midload_writes", wr_data.size(), 1);
      build_frame($urandom_range(2, 6), 1'b1);
      do_start();
      send_frame(20, 1'b0);

      // Reload from DONE with a new image
      build_frame($urandom_range(1, 6), 1'b1);
      do_start();
      send_frame(0, 1'b1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: observed running expected finished");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time instruction loader that sits directly upstream of the `mips_32` core. It receives a framed byte stream over a valid/ready handshake, assembles big-endian 32-bit words, and writes them into instruction memory. It holds the core in reset until a complete, checksum-valid image has been written.

## Interface
- `ADDR_WIDTH`, default 8: instruction-memory word-address width. Capacity is 2^ADDR_WIDTH words; 8 gives 256 words, which matches the core's 10-bit byte PC.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle request to begin a load session.
- `byte_valid`  in  1  upstream byte available.
- `byte_data`  in  8  upstream byte.
- `byte_ready`  out  1  loader accepts a byte this cycle.
- `imem_we`  out  1  instruction-memory write strobe.
- `imem_addr`  out  ADDR_WIDTH  word address of the write.
- `imem_wdata`  out  32  word to write.
- `core_reset`  out  1  reset to the core; high unless an image loaded successfully.
- `done`  out  1  sticky; load succeeded.
- `error`  out  1  sticky; load failed.

## Operation
- Frame format, in byte order:
  - LEN_HI, LEN_LO: 16-bit word count N, big-endian.
  - N×4 data bytes: each word is MSB first.
  - CHK: XOR of every preceding frame byte, including both length bytes.
- A byte is accepted on a rising edge where `byte_valid & byte_ready`. `byte_ready` is decoded combinationally from state.
- FSM states and transitions:
  - IDLE: `byte_ready`=0. `start` → LEN_HI.
  - LEN_HI: `byte_ready`=1. Accepted byte → LEN_LO.
  - LEN_LO: `byte_ready`=1. On accept:
    - if N==0 or N>2^ADDR_WIDTH → ERROR;
    - otherwise → DATA, with word index=0 and byte count=0.
  - DATA: `byte_ready`=1. Each accepted byte shifts `word = {word[23:0], byte_data}`. The 4th accepted byte → WRITE.
  - WRITE: `byte_ready`=0. `imem_we`=1 for exactly one cycle, with `imem_addr`=word index and `imem_wdata`=the assembled word. Next:
    - if word index==N-1 → CHK;
    - otherwise increment word index → DATA.
  - CHK: `byte_ready`=1. Accepted byte equals the running XOR → DONE; otherwise → ERROR.
  - DONE: `done`=1, `core_reset`=0. `start` → LEN_HI.
  - ERROR: `error`=1, `core_reset`=1. `start` → LEN_HI.
- Register clearing on LEN_HI entry: running XOR, word index, byte count and assembled word are all cleared.
- `core_reset`=1 in every state except DONE.
- `start` is ignored in LEN_HI, LEN_LO, DATA, WRITE and CHK.
- Arithmetic and width rules:
  - The XOR accumulator is 8 bits.
  - The word index is ADDR_WIDTH bits. It never wraps, because N is range-checked before any write.
  - The N comparison is done at 17 bits, so that 2^ADDR_WIDTH is representable.
- Stalls: with `byte_valid` low, all state holds indefinitely. There is no timeout.
- Words already written are not rolled back on ERROR.

## Timing
- Reset values (asynchronous):
  - FSM in IDLE.
  - `byte_ready`=0, `imem_we`=0, `imem_addr`=0, `imem_wdata`=0.
  - `core_reset`=1, `done`=0, `error`=0.
- Start: a `start` sampled high at edge t puts the FSM in LEN_HI for cycle t+1. `byte_ready` first rises in that cycle.
- Write latency: the 4th data byte of a word is accepted at edge k. `imem_we` is high during cycle k+1. Memory captures the word at edge k+1.
- Throughput: with back-to-back bytes, one word costs 5 cycles (4 accept cycles plus 1 WRITE cycle).
- Whole frame: first byte accepted at edge t+1 → `done`/`core_reset` change after 5N+3 accepted/idle cycles, at edge t+5N+3.
- DONE entry: `core_reset` falls and `done` rises in the same cycle.
- Restart from DONE: `core_reset` rises, and `done` clears, in the cycle after `start` is sampled.
- `start` and `byte_valid` high together in IDLE: the byte is not accepted, because `byte_ready`=0.
- Reset asserted mid-frame: return to IDLE immediately. `imem_we` drops asynchronously and `core_reset`=1. The partial image stays in memory.

## Test plan
- Happy path: frame 00 02 20 08 00 05 20 09 00 0A 0C, sent back-to-back → `imem_we` pulses with (0, 0x20080005) then (1, 0x2009000A); `done`=1, `core_reset`=0, `error`=0.
- Bad checksum: same frame with CHK=0x0D → both words are still written; `error`=1, `done`=0, `core_reset`=1.
- Length bounds, with ADDR_WIDTH=8:
  - N=0x0000 → ERROR after the 2nd byte, no `imem_we`.
  - N=0x0101 → ERROR, no `imem_we`.
  - N=0x0100 → accepted, with the final write to addr 0xFF.
- Backpressure: insert random `byte_valid` gaps into the happy-path frame → identical writes. `byte_ready`=0 during every WRITE cycle, and a byte presented then is not consumed until the next cycle.
- Reset mid-load: assert `reset` after the 2nd word's WRITE of a 4-word frame → all outputs at reset values within the same cycle. A new `start` plus a full frame then loads correctly from addr 0.
- Reload: from DONE, pulse `start` → `core_reset`=1 the next cycle; a second valid frame returns to DONE with the new words written.
